mc68851_cp_master: RTL and testbench

MC68851_CP_MASTER -- requirements
Module: mc68851_cp_master

---
 rtl/mc68851_cp_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc68851_cp_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc68851_cp_master.sv
// -----------------------------------------------------------------------------
// mc68851_cp_master
//
// CPU-side master for the MC68851 coprocessor interface. One start_i pulse runs
// a full coprocessor command: write the command word, then poll the Response
// register and service its primitives until the coprocessor releases the CPU.
// Supported primitives: null (with or without come-again), transfer operand to
// the coprocessor, and transfer operand to the CPU. Other primitive types fail.
//
// Ports
//   clk_i, rst_n        clock, asynchronous active-low reset
//   start_i             one-cycle request, accepted only while idle
//   cmd_i, operand_i    command word and outgoing operand, latched on start
//   busy_o              command sequence in progress
//   done_o / err_o      one-cycle completion pulses (success / failure)
//   err_code_o          01 illegal primitive, 10 poll limit, 11 ack timeout
//   result_o            last operand read from the coprocessor
//   cs_o, we_o, addr_o, data_o   registered bus request, held until valid_i
//   data_i, valid_i     coprocessor read data and access completion
// -----------------------------------------------------------------------------
module mc68851_cp_master #(
  parameter int POLL_MAX = 255,
  parameter int ACK_MAX  = 15
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] cmd_i,
  input  logic [31:0] operand_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] result_o,
  output logic [4:0]  addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic        we_o,
  output logic        cs_o,
  input  logic        valid_i
);

  localparam logic [4:0] ADDR_RESPONSE = 5'h02;
  localparam logic [4:0] ADDR_COMMAND  = 5'h08;
  localparam logic [4:0] ADDR_OPERAND  = 5'h10;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_POLL    = 2'b10;
  localparam logic [1:0] ERR_ACK     = 2'b11;

  localparam logic [2:0] T_NULL   = 3'b000;
  localparam logic [2:0] T_TO_CP  = 3'b001;
  localparam logic [2:0] T_TO_CPU = 3'b010;

  localparam int POLL_W = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
  localparam int ACK_W  = (ACK_MAX  < 1) ? 1 : $clog2(ACK_MAX + 1);

  // Counter values on which the access that is finishing reaches the limit.
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [POLL_W-1:0] POLL_TOP  = POLL_W'(POLL_MAX);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_WR,
    S_RESP_RD,
    S_OPND_WR,
    S_OPND_RD,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  state_t              gap_next_q, gap_next_d;   // access to launch after GAP
  logic [15:0]         cmd_q, cmd_d;
  logic [31:0]         opnd_q, opnd_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic [ACK_W-1:0]    ack_q, ack_d;

  logic                cs_d, we_d, done_d, err_d;
  logic [4:0]          addr_d;
  logic [31:0]         data_d, result_d;
  logic [1:0]          err_code_d;

  logic                launch;
  state_t              launch_state;
  logic                resp_ca;
  logic [2:0]          resp_type;

  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every variable gets its default here, before any branch, so no
    // path through the block leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    gap_next_d   = gap_next_q;
    cmd_d        = cmd_q;
    opnd_d       = opnd_q;
    poll_d       = poll_q;
    ack_d        = ack_q;
    cs_d         = cs_o;
    we_d         = we_o;
    addr_d       = addr_o;
    data_d       = data_o;
    result_d     = result_o;
    err_code_d   = err_code_o;
    done_d       = 1'b0;
    err_d        = 1'b0;
    launch       = 1'b0;
    launch_state = S_IDLE;
    resp_ca      = data_i[31];
    resp_type    = data_i[30:28];

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cmd_d        = cmd_i;
          opnd_d       = operand_i;
          err_code_d   = 2'b00;
          poll_d       = '0;
          launch       = 1'b1;
          launch_state = S_CMD_WR;
        end
      end

      // The one idle bus cycle between accesses.
      S_GAP: begin
        launch       = 1'b1;
        launch_state = gap_next_q;
      end

      // Bus access states: outputs hold until valid_i or the ack limit.
      default: begin
        if (cs_o) begin
          if (valid_i) begin
            cs_d       = 1'b0;
            state_d    = S_GAP;
            gap_next_d = S_RESP_RD;
            case (state_q)
              S_CMD_WR: ;
              S_OPND_WR: poll_d = '0;
              S_OPND_RD: begin
                poll_d   = '0;
                result_d = data_i;
              end
              default: begin
                case (resp_type)
                  T_NULL: begin
                    if (!resp_ca) begin
                      state_d = S_IDLE;
                      done_d  = 1'b1;
                    end else if (poll_q >= POLL_LAST) begin
                      poll_d     = POLL_TOP;
                      state_d    = S_IDLE;
                      err_d      = 1'b1;
                      err_code_d = ERR_POLL;
                    end else begin
                      poll_d = poll_q + POLL_W'(1);
                    end
                  end
                  T_TO_CP:  gap_next_d = S_OPND_WR;
                  T_TO_CPU: gap_next_d = S_OPND_RD;
                  default: begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                  end
                endcase
              end
            endcase
          end else begin
            ack_d = ack_q + ACK_W'(1);
            if (ack_q == ACK_LAST) begin
              // Abandon the access; the coprocessor never answered.
              cs_d       = 1'b0;
              state_d    = S_IDLE;
              err_d      = 1'b1;
              err_code_d = ERR_ACK;
            end
          end
        end
      end
    endcase

    // Start a new access: bus outputs are set up on the launching edge.
    if (launch) begin
      state_d = launch_state;
      cs_d    = 1'b1;
      ack_d   = '0;
      case (launch_state)
        S_CMD_WR: begin
          addr_d = ADDR_COMMAND;
          we_d   = 1'b1;
          data_d = {16'h0000, cmd_d};
        end
        S_OPND_WR: begin
          addr_d = ADDR_OPERAND;
          we_d   = 1'b1;
          data_d = opnd_q;
        end
        S_OPND_RD: begin
          addr_d = ADDR_OPERAND;
          we_d   = 1'b0;
          data_d = 32'h0;
        end
        default: begin
          addr_d = ADDR_RESPONSE;
          we_d   = 1'b0;
          data_d = 32'h0;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_next_q <= S_IDLE;
      cmd_q      <= '0;
      opnd_q     <= '0;
      poll_q     <= '0;
      ack_q      <= '0;
      cs_o       <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      data_o     <= '0;
      result_o   <= '0;
      err_code_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      cmd_q      <= cmd_d;
      opnd_q     <= opnd_d;
      poll_q     <= poll_d;
      ack_q      <= ack_d;
      cs_o       <= cs_d;
      we_o       <= we_d;
      addr_o     <= addr_d;
      data_o     <= data_d;
      result_o   <= result_d;
      err_code_o <= err_code_d;
      done_o     <= done_d;
      err_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_mc68851_cp_master.sv
// -----------------------------------------------------------------------------
// tb_mc68851_cp_master
//
// Directed bench for mc68851_cp_master (POLL_MAX=4, ACK_MAX=15). A behavioural
// coprocessor answers bus accesses from a per-test response list with a
// programmable ack delay and logs what the master did. A table of command
// scenarios is run in a loop; reset, busy-start, ack timeout and mid-access
// reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mc68851_cp_master;

  localparam int POLL_MAX = 4;
  localparam int ACK_MAX  = 15;

  localparam logic [4:0] A_RESP = 5'h02;
  localparam logic [4:0] A_CMD  = 5'h08;
  localparam logic [4:0] A_OPND = 5'h10;

  logic        clk_i     = 1'b0;
  logic        rst_n     = 1'b1;
  logic        start_i   = 1'b0;
  logic [15:0] cmd_i     = '0;
  logic [31:0] operand_i = '0;
  logic        busy_o, done_o, err_o, we_o, cs_o;
  logic [1:0]  err_code_o;
  logic [31:0] result_o, data_o;
  logic [4:0]  addr_o;
  logic [31:0] data_i  = '0;
  logic        valid_i = 1'b0;

  mc68851_cp_master #(.POLL_MAX(POLL_MAX), .ACK_MAX(ACK_MAX)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .cmd_i      (cmd_i),
    .operand_i  (operand_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .result_o   (result_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .data_i     (data_i),
    .we_o       (we_o),
    .cs_o       (cs_o),
    .valid_i    (valid_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- coprocessor model ----------------
  logic [15:0] resp_tbl [8];
  int          resp_n      = 1;
  int          resp_idx    = 0;
  logic [31:0] rd_val      = '0;
  int          ack_delay   = 0;
  bit          stall_resp  = 1'b0;

  int          cmd_wr_cnt, opnd_wr_cnt, opnd_rd_cnt, resp_rd_cnt;
  int          acc_in_cmd, gap_run, gap_bad, unstable, cs_hi_cnt;
  logic [31:0] last_cmd_data, last_opnd_wr;

  task automatic clear_log();
    cmd_wr_cnt = 0; opnd_wr_cnt = 0; opnd_rd_cnt = 0; resp_rd_cnt = 0;
    acc_in_cmd = 0; gap_run = 0; gap_bad = 0; unstable = 0; cs_hi_cnt = 0;
    last_cmd_data = '0; last_opnd_wr = '0; resp_idx = 0;
  endtask

  initial begin
    int          wait_cnt;
    bit          prev_cs;
    logic [4:0]  acc_addr;
    logic        acc_we;
    logic [31:0] acc_data;
    logic [15:0] word;
    wait_cnt = 0; prev_cs = 1'b0;
    acc_addr = '0; acc_we = 1'b0; acc_data = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n || !cs_o) begin
        valid_i  = 1'b0;
        data_i   = '0;
        wait_cnt = 0;
        if (rst_n && busy_o) gap_run++;
      end else begin
        if (!prev_cs) begin
          if (acc_in_cmd > 0 && gap_run != 1) gap_bad++;
          gap_run  = 0;
          acc_addr = addr_o; acc_we = we_o; acc_data = data_o;
        end else if (addr_o !== acc_addr || we_o !== acc_we || data_o !== acc_data) begin
          unstable++;
        end
        cs_hi_cnt++;
        if (!(stall_resp && !we_o && addr_o == A_RESP) && wait_cnt >= ack_delay) begin
          valid_i = 1'b1;
          acc_in_cmd++;
          data_i = 32'h0;
          if (we_o && addr_o == A_CMD) begin
            cmd_wr_cnt++; last_cmd_data = data_o;
          end else if (we_o && addr_o == A_OPND) begin
            opnd_wr_cnt++; last_opnd_wr = data_o;
          end else if (!we_o && addr_o == A_OPND) begin
            opnd_rd_cnt++; data_i = rd_val;
          end else if (!we_o && addr_o == A_RESP) begin
            resp_rd_cnt++;
            word = resp_tbl[(resp_idx < resp_n) ? resp_idx : resp_n - 1];
            resp_idx++;
            data_i = {word, 16'hA5A5};   // low half is noise the master must ignore
          end
        end else begin
          valid_i = 1'b0;
          wait_cnt++;
        end
      end
      prev_cs = rst_n && cs_o;
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    string           name;
    logic [15:0]     cmd;
    logic [31:0]     opnd;
    logic [0:7][15:0] resp;
    int              n_resp;
    logic [31:0]     rd_val;
    int              ack_delay;
    logic            exp_done;
    logic            exp_err;
    logic [1:0]      exp_code;
    logic [31:0]     exp_result;
    int              exp_resp_rd;
    int              exp_opnd_wr;
    int              exp_opnd_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic start_cmd(input logic [15:0] c, input logic [31:0] op);
    @(negedge clk_i);
    start_i = 1'b1; cmd_i = c; operand_i = op;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string name, output bit got_end);
    got_end = 1'b0;
    for (int c = 0; c < 400 && !got_end; c++) begin
      if (done_o || err_o) got_end = 1'b1;
      else @(negedge clk_i);
    end
    check({name, ".completed"}, 32'(got_end), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    bit got_end;
    for (int i = 0; i < 8; i++) resp_tbl[i] = v.resp[i];
    resp_n = v.n_resp; rd_val = v.rd_val; ack_delay = v.ack_delay;
    clear_log();
    start_cmd(v.cmd, v.opnd);
    check({v.name, ".busy"}, 32'(busy_o), 32'd1);
    check({v.name, ".code_cleared"}, 32'(err_code_o), 32'd0);
    wait_end(v.name, got_end);
    check({v.name, ".done"}, 32'(done_o), 32'(v.exp_done));
    check({v.name, ".err"}, 32'(err_o), 32'(v.exp_err));
    check({v.name, ".code"}, 32'(err_code_o), 32'(v.exp_code));
    check({v.name, ".idle"}, 32'(busy_o), 32'd0);
    check({v.name, ".result"}, result_o, v.exp_result);
    check({v.name, ".cmd_writes"}, cmd_wr_cnt, 1);
    check({v.name, ".cmd_data"}, last_cmd_data, {16'h0000, v.cmd});
    check({v.name, ".resp_reads"}, resp_rd_cnt, v.exp_resp_rd);
    check({v.name, ".opnd_writes"}, opnd_wr_cnt, v.exp_opnd_wr);
    check({v.name, ".opnd_reads"}, opnd_rd_cnt, v.exp_opnd_rd);
    if (v.exp_opnd_wr > 0) check({v.name, ".opnd_data"}, last_opnd_wr, v.opnd);
    check({v.name, ".gap_one_cycle"}, gap_bad, 0);
    check({v.name, ".bus_stable"}, unstable, 0);
    @(negedge clk_i);
    check({v.name, ".pulse_end"}, {30'h0, done_o, err_o}, 32'd0);
    check({v.name, ".code_held"}, 32'(err_code_o), 32'(v.exp_code));
  endtask

  initial begin
    bit got_end;
    bit found;

    //            name     cmd       operand        responses (8 slots)                                                                        n  rd_val        dly done err code  result        rd wr ord
    vecs.push_back('{"null",     16'h1234, 32'h0,        {16'h0000, 112'h0},                                                                       1, 32'h0,        0, 1, 0, 2'b00, 32'h0,        1, 0, 0});
    vecs.push_back('{"poll3",    16'h0042, 32'h0,        {16'h8000, 16'h8000, 16'h8000, 16'h0000, 64'h0},                                          4, 32'h0,        2, 1, 0, 2'b00, 32'h0,        4, 0, 0});
    vecs.push_back('{"xfer",     16'h5555, 32'hDEADBEEF, {16'h1000, 16'h2000, 16'h0000, 80'h0},                                                    3, 32'hCAFEF00D, 0, 1, 0, 2'b00, 32'hCAFEF00D, 3, 1, 1});
    vecs.push_back('{"illegal7", 16'h0007, 32'h0,        {16'h7000, 112'h0},                                                                       1, 32'h0,        0, 0, 1, 2'b01, 32'hCAFEF00D, 1, 0, 0});
    vecs.push_back('{"poll_max", 16'h0100, 32'h0,        {16'h8000, 112'h0},                                                                       1, 32'h0,        0, 0, 1, 2'b10, 32'hCAFEF00D, 4, 0, 0});
    vecs.push_back('{"ca_rd",    16'h0200, 32'h0,        {16'hA000, 16'h0000, 96'h0},                                                              2, 32'h12345678, 1, 1, 0, 2'b00, 32'h12345678, 2, 0, 1});
    vecs.push_back('{"poll_clr", 16'h0300, 32'h0BADF00D, {16'h8000, 16'h8000, 16'h8000, 16'h1000, 16'h8000, 16'h8000, 16'h8000, 16'h0000},     8, 32'h0,        1, 1, 0, 2'b00, 32'h12345678, 8, 1, 0});
    vecs.push_back('{"illegal4", 16'h0400, 32'h0,        {16'h4000, 112'h0},                                                                       1, 32'h0,        0, 0, 1, 2'b01, 32'h12345678, 1, 0, 0});
    vecs.push_back('{"ack14",    16'h0500, 32'h0,        {16'h0000, 112'h0},                                                                       1, 32'h0,       14, 1, 0, 2'b00, 32'h12345678, 1, 0, 0});

    // Reset state
    #3 rst_n = 1'b0;
    #4;
    check("reset.outputs", {26'h0, cs_o, we_o, busy_o, done_o, err_o, |err_code_o}, 32'd0);
    check("reset.addr", 32'(addr_o), 32'd0);
    check("reset.data", data_o, 32'd0);
    check("reset.result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start_i while busy is ignored
    resp_tbl[0] = 16'h0000; resp_n = 1; ack_delay = 5;
    clear_log();
    start_cmd(16'h1111, 32'h0);
    @(negedge clk_i);
    start_i = 1'b1; cmd_i = 16'h2222;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_end("busy_start", got_end);
    check("busy_start.done", 32'(done_o), 32'd1);
    repeat (10) @(negedge clk_i);
    check("busy_start.cmd_writes", cmd_wr_cnt, 1);
    check("busy_start.cmd_data", last_cmd_data, 32'h00001111);
    check("busy_start.idle", 32'(busy_o), 32'd0);

    // Ack timeout: valid_i never comes
    ack_delay = 1000;
    clear_log();
    start_cmd(16'h0600, 32'h0);
    wait_end("ack_to", got_end);
    check("ack_to.err", 32'(err_o), 32'd1);
    check("ack_to.done", 32'(done_o), 32'd0);
    check("ack_to.code", 32'(err_code_o), 32'd3);
    check("ack_to.wait_cycles", cs_hi_cnt, ACK_MAX);
    check("ack_to.cs_dropped", 32'(cs_o), 32'd0);
    check("ack_to.cmd_writes", cmd_wr_cnt, 0);

    // Reset in the middle of a Response read
    ack_delay = 0; stall_resp = 1'b1;
    resp_tbl[0] = 16'h0000; resp_n = 1;
    clear_log();
    start_cmd(16'h0700, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (cs_o && !we_o && addr_o == A_RESP) found = 1'b1;
      else @(negedge clk_i);
    end
    check("mid_rst.reached_resp_rd", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.cs_busy", {30'h0, cs_o, busy_o}, 32'd0);
    check("mid_rst.addr_code", {25'h0, addr_o, err_code_o}, 32'd0);
    check("mid_rst.result", result_o, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1; stall_resp = 1'b0;
    clear_log();
    start_cmd(16'hABCD, 32'h0);
    check("mid_rst.restart_bus", {26'h0, cs_o, we_o, addr_o[3:0]}, {26'h0, 1'b1, 1'b1, 4'h8});
    check("mid_rst.restart_data", data_o, 32'h0000ABCD);
    wait_end("mid_rst", got_end);
    check("mid_rst.done", 32'(done_o), 32'd1);
    check("mid_rst.resp_reads", resp_rd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
